// File: rtl/edge_det_pkg.sv
// rtl/edge_det_pkg.sv - edge mode encoding and mode decode helpers
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int MODE_W = 2;

    function automatic logic mode_has_rise(input edge_mode_e m);
        return (m == EDGE_RISE) || (m == EDGE_BOTH);
    endfunction

    function automatic logic mode_has_fall(input edge_mode_e m);
        return (m == EDGE_FALL) || (m == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/edge_det_multi_if.sv
// rtl/edge_det_multi_if.sv - channel inputs, controls and event outputs of the edge detector
interface edge_det_multi_if #(
    parameter int NUM_CH = 8,
    parameter int DEB_W  = 4
);
    logic [NUM_CH-1:0]   a_i;
    logic [DEB_W-1:0]    debounce_i;
    logic [2*NUM_CH-1:0] mode_i;
    logic [NUM_CH-1:0]   clear_i;
    logic [NUM_CH-1:0]   irq_en_i;
    logic [NUM_CH-1:0]   level_o;
    logic [NUM_CH-1:0]   rising_edge_o;
    logic [NUM_CH-1:0]   falling_edge_o;
    logic [NUM_CH-1:0]   pending_o;
    logic                irq_o;

    modport master (
        output a_i, debounce_i, mode_i, clear_i, irq_en_i,
        input  level_o, rising_edge_o, falling_edge_o, pending_o, irq_o
    );

    modport slave (
        input  a_i, debounce_i, mode_i, clear_i, irq_en_i,
        output level_o, rising_edge_o, falling_edge_o, pending_o, irq_o
    );
endinterface

// File: rtl/edge_det_chan.sv
// rtl/edge_det_chan.sv - one channel: debounce filter, stability counter, edge pulses, pending flag
import edge_det_pkg::*;

module edge_det_chan #(
    parameter int DEB_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic [DEB_W-1:0] debounce,
    input  edge_mode_e       mode,
    input  logic             clear,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             pending
);
    logic [DEB_W-1:0] cnt_q;
    logic             differ;
    logic             update;
    logic             rise_ev;
    logic             fall_ev;

    // An update happens once the differing input has outlasted the threshold;
    // the >= compare lets a lowered threshold fire on the very next sample.
    always_comb begin
        differ  = a ^ level;
        update  = differ && (cnt_q >= debounce);
        rise_ev = update && a && mode_has_rise(mode);
        fall_ev = update && !a && mode_has_fall(mode);
    end

    // Filter/counter state, registered pulses and sticky flag (set wins over clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            level   <= 1'b0;
            cnt_q   <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            pending <= 1'b0;
        end else begin
            rise    <= rise_ev;
            fall    <= fall_ev;
            pending <= (pending & ~clear) | rise_ev | fall_ev;
            if (!differ) begin
                cnt_q <= '0;
            end else if (update) begin
                level <= a;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DEB_W'(1);
            end
        end
    end
endmodule

// File: rtl/edge_det_multi.sv
// rtl/edge_det_multi.sv - multi-channel debounced edge detector with sticky flags and interrupt
import edge_det_pkg::*;

module edge_det_multi #(
    parameter int NUM_CH = 8,
    parameter int DEB_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    edge_det_multi_if.slave bus
);
    logic [NUM_CH-1:0] level_w;
    logic [NUM_CH-1:0] rise_w;
    logic [NUM_CH-1:0] fall_w;
    logic [NUM_CH-1:0] pend_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        edge_det_chan #(
            .DEB_W (DEB_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .a        (bus.a_i[i]),
            .debounce (bus.debounce_i),
            .mode     (edge_mode_e'(bus.mode_i[MODE_W*i +: MODE_W])),
            .clear    (bus.clear_i[i]),
            .level    (level_w[i]),
            .rise     (rise_w[i]),
            .fall     (fall_w[i]),
            .pending  (pend_w[i])
        );
    end

    assign bus.level_o        = level_w;
    assign bus.rising_edge_o  = rise_w;
    assign bus.falling_edge_o = fall_w;
    assign bus.pending_o      = pend_w;
    // The only combinational output: flags masked by enables.
    assign bus.irq_o          = |(pend_w & bus.irq_en_i);
endmodule
